// File: rtl/glb_pe_sequencer_pkg.sv
// Shared definitions for the GLB/PE cluster tile sequencer: state encoding,
// default GLB base addresses and the wait-counter width.
package glb_pe_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        DIST,
        START,
        COMPUTE,
        RD_REQ,
        RD_CAP,
        RD_OUT
    } state_e;

    localparam int DEF_WGHT_BASE = 0;
    localparam int DEF_IACT_BASE = 100;
    localparam int DEF_PSUM_BASE = 500;
    localparam int TMO_W         = 12;

endpackage

// File: rtl/glb_stream_writer.sv
// Counts accepted stream words and turns each one into a registered GLB
// write strobe at BASE + index; flags the last word of the burst.
module glb_stream_writer #(
    parameter int ADDR_BITWIDTH = 10,
    parameter int COUNT         = 9,
    parameter int BASE          = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     accept_i,
    output logic                     last_o,
    output logic                     write_en_o,
    output logic [ADDR_BITWIDTH-1:0] w_addr_o
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;

    assign last_o     = accept_i && (cnt_q == CNT_W'(COUNT - 1));
    assign write_en_o = we_q;
    assign w_addr_o   = addr_q;

    // Counter self-wraps on the last word so the next burst starts at BASE.
    always_comb begin
        cnt_d  = cnt_q;
        we_d   = accept_i;
        addr_d = addr_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            addr_d = ADDR_BITWIDTH'(BASE) + ADDR_BITWIDTH'(cnt_q);
            cnt_d  = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/glb_pe_sequencer.sv
// One-job-per-go controller for a GLB + PE cluster tile: loads weights and
// iacts into the GLBs, runs distribution and compute, then drains psums.
module glb_pe_sequencer
    import glb_pe_sequencer_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_WGHT      = 9,
    parameter int NUM_IACT      = 25,
    parameter int NUM_PSUM      = 9,
    parameter int WGHT_BASE     = DEF_WGHT_BASE,
    parameter int IACT_BASE     = DEF_IACT_BASE,
    parameter int PSUM_BASE     = DEF_PSUM_BASE,
    parameter int TIMEOUT       = 4095
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_go,
    output logic                     busy,
    output logic                     job_done,
    output logic                     error,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     write_en_wght,
    output logic                     write_en_iact,
    output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    output logic [DATA_BITWIDTH-1:0] w_data,
    output logic                     enable_wght,
    output logic                     enable_iact,
    output logic                     start,
    input  logic                     load_done,
    input  logic                     compute_done,
    output logic                     req_read_psum,
    output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0] r_data_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data
);

    localparam int PCNT_W = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1;

    state_e                   state_q, state_d;
    logic [TMO_W-1:0]         wait_q, wait_d;
    logic [PCNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                     error_q, error_d;
    logic                     job_done_q, job_done_d;
    logic                     busy_q, in_ready_q, enable_q, start_q, req_q, out_valid_q;
    logic [ADDR_BITWIDTH-1:0] r_addr_q;
    logic [DATA_BITWIDTH-1:0] w_data_q, out_data_q;
    logic                     go_clr, acc_w, acc_a, w_last, a_last;

    assign acc_w = (state_q == LOAD_W) && in_valid && in_ready_q;
    assign acc_a = (state_q == LOAD_A) && in_valid && in_ready_q;

    glb_stream_writer #(
        .ADDR_BITWIDTH(ADDR_BITWIDTH),
        .COUNT        (NUM_WGHT),
        .BASE         (WGHT_BASE)
    ) u_wr_wght (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (go_clr),
        .accept_i  (acc_w),
        .last_o    (w_last),
        .write_en_o(write_en_wght),
        .w_addr_o  (w_addr_wght)
    );

    glb_stream_writer #(
        .ADDR_BITWIDTH(ADDR_BITWIDTH),
        .COUNT        (NUM_IACT),
        .BASE         (IACT_BASE)
    ) u_wr_iact (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (go_clr),
        .accept_i  (acc_a),
        .last_o    (a_last),
        .write_en_o(write_en_iact),
        .w_addr_o  (w_addr_iact)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        rd_cnt_d   = rd_cnt_q;
        error_d    = error_q;
        job_done_d = 1'b0;
        go_clr     = 1'b0;
        case (state_q)
            IDLE: if (cfg_go) begin
                state_d  = LOAD_W;
                error_d  = 1'b0;
                go_clr   = 1'b1;
                rd_cnt_d = '0;
            end
            LOAD_W: if (w_last) state_d = LOAD_A;
            LOAD_A: if (a_last) state_d = DIST;
            DIST: begin
                if (load_done) begin
                    state_d = START;
                end else if (wait_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            START: state_d = COMPUTE;
            COMPUTE: begin
                if (compute_done) begin
                    state_d  = RD_REQ;
                    rd_cnt_d = '0;
                end else if (wait_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: state_d = RD_OUT;
            RD_OUT: if (out_valid_q && out_ready) begin
                if (rd_cnt_q == PCNT_W'(NUM_PSUM - 1)) begin
                    state_d    = IDLE;
                    job_done_d = 1'b1;
                end else begin
                    state_d  = RD_REQ;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Level outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            rd_cnt_q    <= '0;
            error_q     <= 1'b0;
            job_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            enable_q    <= 1'b0;
            start_q     <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            r_addr_q    <= '0;
            w_data_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rd_cnt_q    <= rd_cnt_d;
            error_q     <= error_d;
            job_done_q  <= job_done_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == LOAD_W) || (state_d == LOAD_A);
            enable_q    <= (state_d == DIST);
            start_q     <= (state_d == START);
            req_q       <= (state_d == RD_REQ);
            out_valid_q <= (state_d == RD_OUT);
            if (state_d == RD_REQ)
                r_addr_q <= ADDR_BITWIDTH'(PSUM_BASE) + ADDR_BITWIDTH'(rd_cnt_d);
            if (acc_w || acc_a)
                w_data_q <= in_data;
            if (state_q == RD_CAP)
                out_data_q <= r_data_psum;
        end
    end

    assign busy          = busy_q;
    assign job_done      = job_done_q;
    assign error         = error_q;
    assign in_ready      = in_ready_q;
    assign w_data        = w_data_q;
    assign enable_wght   = enable_q;
    assign enable_iact   = enable_q;
    assign start         = start_q;
    assign req_read_psum = req_q;
    assign r_addr_psum   = r_addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;

endmodule

// File: tb/tb_glb_pe_sequencer.sv
// Self-checking bench: table of job scenarios plus timeout and mid-job reset
// sequences, checked against GLB/output models built from the job rules.
module tb_glb_pe_sequencer;

    localparam int DW = 16, AW = 10, NW = 9, NA = 25, NP = 9;
    localparam int WB = 0, IB = 100, PB = 500, TMO = 4095;

    logic          clk = 1'b0, reset = 1'b0;
    logic          cfg_go = 1'b0, in_valid = 1'b0, load_done = 1'b0, compute_done = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0, r_data_psum = '0;
    logic          busy, job_done, error, in_ready, write_en_wght, write_en_iact;
    logic [AW-1:0] w_addr_wght, w_addr_iact, r_addr_psum;
    logic [DW-1:0] w_data, out_data;
    logic          enable_wght, enable_iact, start, req_read_psum, out_valid;

    always #5 clk = ~clk;

    glb_pe_sequencer dut (
        .clk(clk), .reset(reset), .cfg_go(cfg_go), .busy(busy), .job_done(job_done), .error(error),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .write_en_wght(write_en_wght), .write_en_iact(write_en_iact),
        .w_addr_wght(w_addr_wght), .w_addr_iact(w_addr_iact), .w_data(w_data),
        .enable_wght(enable_wght), .enable_iact(enable_iact), .start(start),
        .load_done(load_done), .compute_done(compute_done),
        .req_read_psum(req_read_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // psum GLB: one-cycle read latency
    logic [DW-1:0] psum_mem [0:(1<<AW)-1];
    always @(posedge clk) if (req_read_psum) r_data_psum <= psum_mem[r_addr_psum];

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observed traffic, sampled on the falling edge
    logic [AW+DW-1:0] wq[$], aq[$];
    logic [DW-1:0]    oq[$];
    int               done_cnt, start_cnt, viol;
    logic             hold_prev = 1'b0;
    logic [DW-1:0]    hold_data = '0;
    always @(negedge clk) begin
        if (write_en_wght) wq.push_back({w_addr_wght, w_data});
        if (write_en_iact) aq.push_back({w_addr_iact, w_data});
        if (out_valid && out_ready) oq.push_back(out_data);
        if (job_done) done_cnt++;
        if (start) start_cnt++;
        if (hold_prev && out_data !== hold_data) viol++;
        if (out_valid && !out_ready && req_read_psum) viol++;
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
    end

    typedef struct {
        int mode;        // 0 back-to-back, 1 alternate bubbles, 2 random bubbles
        int stall_word;  // output word index to stall on, -1 none
        int stall_len;
        int load_dly;
        bit spur;        // cfg_go in LOAD_A and compute_done in DIST
        int exp_w, exp_a, exp_out, exp_done;
    } vec_t;
    vec_t vecs[5];

    task automatic step();
        @(posedge clk); #1;
    endtask

    // kind: 0 full job, 1 stop once in RD_OUT, 2 never send compute_done
    task automatic run_job(input vec_t v, input int kind);
        logic [DW-1:0] words [NW+NA];
        int idx, cyc, stall_left;
        bit acc, bub;
        for (int i = 0; i < NW + NA; i++) words[i] = DW'($urandom);
        wq.delete(); aq.delete(); oq.delete();
        done_cnt = 0; start_cnt = 0; viol = 0;
        step(); cfg_go = 1'b1;
        step(); cfg_go = 1'b0;
        check("go_busy", busy, 1);
        check("go_error_cleared", error, 0);
        idx = 0; cyc = 0;
        while (idx < NW + NA && cyc < 1000) begin
            case (v.mode)
                1: bub = (cyc % 2) == 1;
                2: bub = ($urandom_range(0, 2) == 0);
                default: bub = 1'b0;
            endcase
            in_valid = !bub;
            in_data  = words[idx];
            cfg_go   = v.spur && idx == 15 && !bub;
            acc      = in_valid && in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; cfg_go = 1'b0;
        check("load_word_count", idx, NW + NA);
        cyc = 0;
        while (!(enable_wght && enable_iact) && cyc < 50) begin step(); cyc++; end
        check("dist_enables", {enable_wght, enable_iact, in_ready}, 3'b110);
        if (v.spur) begin compute_done = 1'b1; step(); compute_done = 1'b0; end
        repeat (v.load_dly) step();
        check("dist_held", {enable_wght, start}, 2'b10);
        load_done = 1'b1; step(); load_done = 1'b0;
        check("start_after_load", {start, enable_wght}, 2'b10);
        if (kind == 2) begin
            cyc = 0;
            while (!error && cyc < 5000) begin step(); cyc++; end
            check("tmo_cycles", cyc, TMO + 1);
            check("tmo_idle", {busy, enable_wght, enable_iact, req_read_psum, out_valid}, 5'b0);
            repeat (3) step();
            check("tmo_no_done", done_cnt, 0);
            check("tmo_error_sticky", error, 1);
            return;
        end
        repeat (3) step();
        check("start_pulses", start_cnt, 1);
        compute_done = 1'b1; step(); compute_done = 1'b0;
        stall_left = v.stall_len; cyc = 0;
        while (oq.size() < NP && cyc < 2000) begin
            if (kind == 1 && out_valid) begin out_ready = 1'b0; return; end
            out_ready = 1'b1;
            if (out_valid && oq.size() == v.stall_word && stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end
            step(); cyc++;
        end
        out_ready = 1'b0;
        repeat (3) step();
        check("wght_writes", wq.size(), v.exp_w);
        check("iact_writes", aq.size(), v.exp_a);
        for (int i = 0; i < NW && i < wq.size(); i++)
            check($sformatf("wght_write[%0d]", i), wq[i], {AW'(WB + i), words[i]});
        for (int i = 0; i < NA && i < aq.size(); i++)
            check($sformatf("iact_write[%0d]", i), aq[i], {AW'(IB + i), words[NW + i]});
        check("out_words", oq.size(), v.exp_out);
        for (int i = 0; i < NP && i < oq.size(); i++)
            check($sformatf("out_data[%0d]", i), oq[i], psum_mem[(PB + i) % (1 << AW)]);
        check("job_done_pulses", done_cnt, v.exp_done);
        check("stall_stable_no_req", viol, 0);
        check("end_idle", {busy, error}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) psum_mem[i] = DW'($urandom);
        vecs[0] = '{0, -1, 0, 5, 1'b0, NW, NA, NP, 1};  // basic job
        vecs[1] = '{1, -1, 0, 5, 1'b0, NW, NA, NP, 1};  // alternating input bubbles
        vecs[2] = '{0,  3, 20, 5, 1'b0, NW, NA, NP, 1}; // backpressure on word 3
        vecs[3] = '{0, -1, 0, 5, 1'b1, NW, NA, NP, 1};  // spurious cfg_go / compute_done
        vecs[4] = '{2,  8, 5, 0, 1'b0, NW, NA, NP, 1};  // random bubbles, stall on last

        repeat (3) @(posedge clk); #1;
        check("reset_ctrl", {busy, job_done, error, in_ready, write_en_wght, write_en_iact,
                             enable_wght, enable_iact, start, req_read_psum, out_valid}, 11'b0);
        check("reset_data", {w_addr_wght, w_addr_iact, w_data, r_addr_psum, out_data}, 56'b0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], 0);

        run_job(vecs[0], 2);
        run_job(vecs[0], 0);

        run_job(vecs[0], 1);
        check("pre_reset_rd_out", {busy, out_valid}, 2'b11);
        #2 reset = 1'b0;
        #1;
        check("midrst_ctrl", {busy, job_done, error, in_ready, write_en_wght, write_en_iact,
                              enable_wght, enable_iact, start, req_read_psum, out_valid}, 11'b0);
        check("midrst_data", {w_addr_wght, w_addr_iact, w_data, r_addr_psum, out_data}, 56'b0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        run_job(vecs[4], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/glb_pe_sequencer.md
Name: glb_pe_sequencer

Overview:
- Top-level controller for one local GLB + PE cluster tile.
- Accepts one input stream of words: weights first, then activations. Writes them into the weight and iact GLBs.
- Pulses the router enables to distribute the operands into the PE spads, then starts compute and waits for it to finish.
- Drains the psum GLB to an output stream with valid/ready flow control. One job per cfg_go.

Parameters:
- DATA_BITWIDTH, 16, word width of every data path
- ADDR_BITWIDTH, 10, GLB address width
- NUM_WGHT, 9, weight words per job (kernel_size^2)
- NUM_IACT, 25, activation words per job (act_size^2)
- NUM_PSUM, 9, psum words drained per job
- WGHT_BASE, 0, first GLB weight write address
- IACT_BASE, 100, first GLB iact write address
- PSUM_BASE, 500, first GLB psum read address
- TIMEOUT, 4095, maximum cycles to wait for load_done or compute_done; 12-bit counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_go  in  1  single-cycle job start; ignored unless in IDLE
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the last psum word is accepted
- error  out  1  sticky timeout flag; cleared by reset or by the next accepted cfg_go
- in_valid  in  1  input word valid
- in_ready  out  1  high in LOAD_W and LOAD_A only
- in_data  in  DATA_BITWIDTH  input word
- write_en_wght  out  1  weight GLB write strobe
- write_en_iact  out  1  iact GLB write strobe
- w_addr_wght  out  ADDR_BITWIDTH  weight GLB write address
- w_addr_iact  out  ADDR_BITWIDTH  iact GLB write address
- w_data  out  DATA_BITWIDTH  write data, shared by both GLBs
- enable_wght  out  1  router weight-distribution enable
- enable_iact  out  1  router iact-distribution enable
- start  out  1  one-cycle PE cluster compute start
- load_done  in  1  PE cluster reports spads loaded
- compute_done  in  1  PE cluster reports compute finished
- req_read_psum  out  1  psum GLB read request; data returns 1 cycle later
- r_addr_psum  out  ADDR_BITWIDTH  psum GLB read address
- r_data_psum  in  DATA_BITWIDTH  psum GLB read data
- out_valid  out  1  output word valid
- out_ready  in  1  output word accepted
- out_data  out  DATA_BITWIDTH  output word

Behaviour:
- Reset values: state=IDLE; counters=0; error=0; all outputs 0, including in_ready, strobes, enables, start, req and out_valid.
- Registered outputs. All transfers complete on a rising edge where valid and ready are both high.
- State machine:
  - IDLE: on cfg_go go to LOAD_W, clear cnt and error.
  - LOAD_W: each in_valid & in_ready gives write_en_wght=1, w_addr_wght=WGHT_BASE+cnt, w_data=in_data in the next cycle. When cnt reaches NUM_WGHT-1, go to LOAD_A with cnt=0.
  - LOAD_A: same scheme using the iact strobe and IACT_BASE, NUM_IACT words. Then go to DIST.
  - DIST: enable_wght and enable_iact are held high. Wait for load_done, then go to START.
  - START: start=1 for exactly one cycle, then go to COMPUTE.
  - COMPUTE: wait for compute_done, then go to RD_REQ with cnt=0.
  - RD_REQ: req_read_psum=1, r_addr_psum=PSUM_BASE+cnt for one cycle, then go to RD_CAP.
  - RD_CAP: latch r_data_psum into out_data, set out_valid, go to RD_OUT.
  - RD_OUT: hold out_data stable until out_ready. On accept: if cnt=NUM_PSUM-1, pulse job_done and go to IDLE; otherwise cnt+1 and go to RD_REQ.
- Timeout: in DIST and COMPUTE, a wait counter increments every cycle. If it reaches TIMEOUT: set error=1, drop all enables, go to IDLE, no job_done.
- Early done: load_done or compute_done arriving in any state other than the one waiting for it is ignored.
- cfg_go while busy is ignored, with no side effects.
- in_valid with in_ready low is not consumed. Gaps in in_valid stall the load without affecting addresses.
- out_ready held low stalls RD_OUT indefinitely, with no timeout.
- Address arithmetic is modulo 2^ADDR_BITWIDTH and wraps silently.
- Reset asserted mid-job: every output returns to its reset value asynchronously. The job is abandoned; partial GLB contents are undefined.

Decomposition:
- Shared package holds the state encoding (IDLE, LOAD_W, LOAD_A, DIST, START, COMPUTE, RD_REQ, RD_CAP, RD_OUT) and the default base addresses.
- One natural sub-module: glb_stream_writer, the counter-plus-address/strobe generator. It is instantiated twice, for weights and iacts.

Test Plan:
- Basic job: cfg_go, then 34 words streamed back-to-back (9 weights, 25 iacts). Expect weight writes at addresses 0..8 and iact writes at 100..124. load_done after 5 cycles gives start high for exactly 1 cycle. compute_done then gives 9 reads at 500..508. With out_ready=1, out_data matches the GLB model and job_done pulses once.
- Input bubbles: in_valid toggled 1,0,1,0 during the load. Expect no duplicate or skipped addresses; the weight/iact boundary lands exactly at word 9.
- Output backpressure: out_ready low for 20 cycles on word 3. Expect out_data stable, no new req_read_psum, and all 9 words delivered in order.
- Timeout: compute_done never asserted. Expect error=1 after 4095 COMPUTE cycles, state IDLE, no job_done. A following cfg_go clears error.
- Spurious events: cfg_go during LOAD_A and compute_done during DIST. Expect both ignored and the job completes normally.
- Reset mid-job: reset pulled low in RD_OUT. Expect all outputs 0 immediately and busy=0; a new job after reset completes correctly.
